// File: rtl/uart_tx_drain.sv
// uart_tx_drain: pops the shared byte FIFO and launches each word into the UART transmitter.
// Define UART_TX_DRAIN_GAP_EN to insert GAP_CYCLES idle cycles between words.
module uart_tx_drain #(
    parameter int WIDTH      = 8,
    parameter int CNT_WIDTH  = 16,
    parameter int GAP_CYCLES = 2
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 enable,
    input  logic                 fifo_empty,
    input  logic                 fifo_full,
    input  logic                 fifo_push,
    input  logic [WIDTH-1:0]     fifo_data,
    output logic                 fifo_pop,
    input  logic                 tx_busy,
    output logic                 tx_start,
    output logic [WIDTH-1:0]     tx_data,
    output logic [CNT_WIDTH-1:0] sent_count,
    output logic                 idle
);
    typedef enum logic [2:0] {
        IDLE, POP, CAPTURE, START, WAIT_ACK, WAIT_DONE
`ifdef UART_TX_DRAIN_GAP_EN
        , GAP
`endif
    } state_t;
    state_t state, state_nx;
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state      <= IDLE;
            tx_data    <= '0;
            sent_count <= '0;
        end else begin
            state <= state_nx;
            if (state == CAPTURE) tx_data <= fifo_data;
            if (state == START) sent_count <= sent_count + 1'b1;
        end
    end
`ifdef UART_TX_DRAIN_GAP_EN
    logic [7:0] gap_cnt;
    always_ff @(posedge clock) begin
        if (!resetn) gap_cnt <= '0;
        else if (state == WAIT_DONE && !tx_busy) gap_cnt <= 8'(GAP_CYCLES - 1);
        else if (state == GAP) gap_cnt <= gap_cnt - 1'b1;
    end
`endif
    // A full FIFO drops a simultaneous push+pop, so the pop is retried from IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (enable && !fifo_empty && !tx_busy) state_nx = POP;
            POP:       state_nx = (fifo_push && fifo_full) ? IDLE : CAPTURE;
            CAPTURE:   state_nx = START;
            START:     state_nx = WAIT_ACK;
            WAIT_ACK:  if (tx_busy) state_nx = WAIT_DONE;
`ifdef UART_TX_DRAIN_GAP_EN
            WAIT_DONE: if (!tx_busy) state_nx = GAP;
            GAP:       if (gap_cnt == 8'd0) state_nx = IDLE;
`else
            WAIT_DONE: if (!tx_busy) state_nx = IDLE;
`endif
            default:   state_nx = IDLE;
        endcase
    end
    assign fifo_pop = (state == POP);
    assign tx_start = (state == START);
    assign idle     = (state == IDLE);
endmodule

// File: tb/tb_uart_tx_drain.sv
// tb_uart_tx_drain: directed checks of uart_tx_drain against a small FIFO model.
// Works with or without UART_TX_DRAIN_GAP_EN (gap of 3 cycles when defined).
module tb_uart_tx_drain;
    localparam int GAP = 3;
`ifdef UART_TX_DRAIN_GAP_EN
    localparam int EXIT = GAP + 1;
`else
    localparam int EXIT = 1;
`endif
    logic clock = 0, resetn = 0, enable = 0, fifo_empty = 1, fifo_full = 0;
    logic fifo_push = 0, tx_busy = 0, fifo_pop, tx_start, idle;
    logic [7:0] fifo_data = 0, tx_data;
    logic [15:0] sent_count;
    logic [7:0] q[$];
    int pass_n = 0, total_n = 0, seen;

    always #5 clock = ~clock;

    uart_tx_drain #(.WIDTH(8), .CNT_WIDTH(16), .GAP_CYCLES(GAP)) dut (
        .clock(clock), .resetn(resetn), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_full(fifo_full), .fifo_push(fifo_push), .fifo_data(fifo_data),
        .fifo_pop(fifo_pop), .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
        .sent_count(sent_count), .idle(idle)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_n++;
        assert (obs === exp) pass_n++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic upd();
        fifo_empty = (q.size() == 0);
        fifo_full  = (q.size() >= 4);
    endtask

    // FIFO model: data_out is valid the cycle after an accepted pop, 0 otherwise.
    task automatic tick();
        logic pa;
        pa = fifo_pop && !(fifo_push && fifo_full) && (q.size() > 0);
        @(posedge clock);
        #1;
        if (pa) fifo_data = q.pop_front();
        else fifo_data = 8'h00;
        upd();
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (!tx_start && n < 20) begin
            tick();
            n++;
        end
        chk(tag, tx_start, 1);
    endtask

    // Called in the START cycle: busy rises immediately and stays high n cycles.
    task automatic busy_then_idle(input int n, input bit drop, input string tag);
        int k = 0;
        tx_busy = 1;
        tick();
        chk({tag, "_pulse"}, tx_start, 0);
        repeat (n - 1) tick();
        chk({tag, "_busy"}, idle, 0);
        if (drop) enable = 0;
        tx_busy = 0;
        do begin
            tick();
            k++;
        end while (!idle && k < 20);
        chk({tag, "_exit"}, k, EXIT);
    endtask

    initial begin
        upd();
        tick();
        tick();
        chk("rst_idle", idle, 1);
        chk("rst_cnt", sent_count, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_pop", fifo_pop, 0);
        chk("rst_start", tx_start, 0);
        resetn = 1;
        enable = 1;
        seen = 0;
        repeat (20) begin
            tick();
            if (fifo_pop || tx_start || !idle) seen++;
        end
        chk("empty_no_pop", seen, 0);
        chk("empty_cnt", sent_count, 0);

        enable = 0;
        q = '{8'h55};
        upd();
        tick();
        enable = 1;
        tick();
        chk("t2_pop", fifo_pop, 1);
        tick();
        chk("t2_capture", fifo_pop, 0);
        tick();
        chk("t2_start", tx_start, 1);
        chk("t2_data", tx_data, 8'h55);
        chk("t2_cnt_pre", sent_count, 0);
        busy_then_idle(10, 0, "t2");
        chk("t2_cnt", sent_count, 1);
        chk("t2_hold", tx_data, 8'h55);

        enable = 0;
        q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        upd();
        tick();
        enable = 1;
        tick();
        chk("t3_pop", fifo_pop, 1);
        fifo_push = 1;
        tick();
        fifo_push = 0;
        chk("t3_reject_idle", idle, 1);
        chk("t3_q_kept", q.size(), 4);
        chk("t3_cnt_kept", sent_count, 1);
        tick();
        chk("t3_retry_pop", fifo_pop, 1);
        tick();
        tick();
        chk("t3_start", tx_start, 1);
        chk("t3_data", tx_data, 8'hA1);
        enable = 0;
        busy_then_idle(3, 0, "t3");
        chk("t3_cnt", sent_count, 2);
        chk("t3_q_left", q.size(), 3);

        resetn = 0;
        tick();
        resetn = 1;
        chk("t4_rst_cnt", sent_count, 0);
        q.delete();
        q = '{8'h01, 8'h02, 8'h03};
        upd();
        enable = 1;
        wait_start("t4_w1_start");
        chk("t4_w1_data", tx_data, 8'h01);
        busy_then_idle(4, 0, "t4_w1");
        tick();
        chk("t4_next_pop", fifo_pop, 1);
        wait_start("t4_w2_start");
        chk("t4_w2_data", tx_data, 8'h02);
        busy_then_idle(5, 1, "t4_w2");
        seen = 0;
        repeat (10) begin
            tick();
            if (fifo_pop || !idle) seen++;
        end
        chk("t4_no_pop", seen, 0);
        chk("t4_cnt", sent_count, 2);
        chk("t4_q_left", q.size(), 1);
        chk("t4_hold", tx_data, 8'h02);

        enable = 1;
        wait_start("t5_start");
        chk("t5_data", tx_data, 8'h03);
        tx_busy = 1;
        tick();
        tick();
        chk("t5_in_word", idle, 0);
        resetn = 0;
        tick();
        chk("t5_idle", idle, 1);
        chk("t5_start", tx_start, 0);
        chk("t5_data0", tx_data, 0);
        chk("t5_cnt0", sent_count, 0);
        resetn = 1;
        tx_busy = 0;
        enable = 0;
        tick();
        chk("t5_stay_idle", idle, 1);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule

// File: doc/uart_tx_drain.md
Name: uart_tx_drain

Overview:
- Sequencer between the shared byte FIFO and the UART transmitter.
- Whenever the transmitter is free, pops one word from the FIFO and captures it one cycle later, when the FIFO's registered data_out is valid.
- Launches the word with a one-cycle start pulse, then tracks the transmitter's busy handshake until the word is done.
- Is the only popper of the FIFO. Handles the FIFO's rule that a simultaneous push+pop is dropped when the FIFO is full.

Parameters:
- WIDTH, 8, data word width; must match the FIFO width and the transmitter width.
- CNT_WIDTH, 16, width of the sent-word counter.
- GAP_CYCLES, 2, idle cycles inserted between words; used only with UART_TX_DRAIN_GAP_EN; legal range 1..255.

Ports:
- clock  in  1  single clock; all logic on posedge.
- resetn  in  1  synchronous active-low reset; sampled on posedge clock only.
- enable  in  1  allows starting a new word; sampled in IDLE only.
- fifo_empty  in  1  FIFO empty flag.
- fifo_full  in  1  FIFO full flag.
- fifo_push  in  1  producer push request to the same FIFO, observed for collision detection.
- fifo_data  in  WIDTH  FIFO data_out; valid the cycle after an accepted pop, 0 otherwise.
- fifo_pop  out  1  pop request to the FIFO.
- tx_busy  in  1  transmitter busy.
- tx_start  out  1  one-cycle launch pulse.
- tx_data  out  WIDTH  word to transmit; stable from START until WAIT_DONE exits.
- sent_count  out  CNT_WIDTH  number of words launched.
- idle  out  1  high when state==IDLE.

Behaviour:
- Reset (resetn==0 at a posedge, any state):
  - state=IDLE; fifo_pop=0, tx_start=0, tx_data=0, sent_count=0, idle=1.
  - Any word in flight is abandoned. The transmitter is not notified.
- Outputs are decoded from the registered state: fifo_pop=1 only in POP; tx_start=1 only in START.
- States and transitions:
  - IDLE: go to POP iff enable && !fifo_empty && !tx_busy; otherwise stay.
  - POP:
    - Pop is accepted iff !(fifo_push && fifo_full).
    - Accepted: go to CAPTURE.
    - Rejected (collision: FIFO full and producer pushing in the same cycle, so the FIFO performs neither action): go to IDLE, increment nothing, retry later.
  - CAPTURE: tx_data <= fifo_data; go to START.
  - START: tx_start=1 for exactly this cycle; sent_count <= sent_count+1, wrapping modulo 2^CNT_WIDTH; go to WAIT_ACK.
  - WAIT_ACK: stay until tx_busy==1, then go to WAIT_DONE. A busy rising in the START cycle itself is also accepted: it is seen in WAIT_ACK on the next cycle.
  - WAIT_DONE: stay while tx_busy==1; on tx_busy==0 go to IDLE (or GAP, see Optional Feature).
- Latency: condition true in IDLE at cycle N → fifo_pop at N+1 → capture at N+2 → tx_start at N+3.
  - Minimum word-to-word spacing = 4 cycles + transmitter busy time.
- enable deasserted mid-word: the current word completes; no new pop is issued.
- FIFO empty: no pop is ever issued while fifo_empty==1.
- Exactly one FIFO pop per launched word. No duplicated or skipped words, including across collision retries.
- tx_data holds its last value in IDLE; it is not cleared after a word.

Optional Feature:
- Macro UART_TX_DRAIN_GAP_EN.
- Defined:
  - WAIT_DONE on tx_busy==0 enters GAP, with an 8-bit counter loaded to GAP_CYCLES-1.
  - GAP decrements the counter each cycle and goes to IDLE when it reaches 0, giving exactly GAP_CYCLES cycles in GAP.
  - Reset clears the counter.
- Not defined: the GAP state and counter are absent; WAIT_DONE goes directly to IDLE.

Test Plan:
- Reset, FIFO empty, enable=1, 20 cycles → fifo_pop never 1, tx_start never 1, idle=1, sent_count=0.
- FIFO holds 0x55, tx_busy low, enable rises at cycle 0 → fifo_pop at cycle 1, tx_data=0x55 and tx_start at cycle 3. Transmitter busy 10 cycles → idle returns; sent_count=1.
- FIFO full (length 4) holding 0xA1..0xA4, fifo_push=1 during the POP cycle → pop rejected, state IDLE; retry with push=0 → 0xA1 sent.
- Words 0x01,0x02,0x03 queued, enable dropped during 0x02's WAIT_DONE → 0x02 completes; 0x03 stays in FIFO; sent_count=2.
- resetn=0 during WAIT_DONE → next cycle idle=1, tx_start=0, tx_data=0, sent_count=0.
- With UART_TX_DRAIN_GAP_EN, GAP_CYCLES=3, two words back-to-back → exactly 3 cycles between busy falling and re-entering IDLE, then the next pop.
